masked_ram_port_ctrl: RTL
=========================

// Module: masked_ram_port_ctrl
// PURPOSE
//   Initiator-side controller for a 1R1W masked-write SRAM macro (64 x 304b, 16 lanes x 19b, 1-cycle read).
//   Sequences post-reset zero-fill, forwards lane-masked writes, issues reads and captures read data exactly
//   one cycle after issue into a response FIFO with valid/ready backpressure. Sits between a core-side user
//   (e.g. tag/data array logic) and the RAM macro's W0_*/R0_* ports.
// PARAMETERS
//   ADDR_W      6    RAM address width; DEPTH = 2**ADDR_W
//   LANES       16   write-mask lanes
//   LANE_W      19   bits per lane; DATA_W = LANES*LANE_W = 304
//   RESP_DEPTH  3    response FIFO entries; sustains 1 read/cycle with no comb ready path
// PORTS
//   clock          in   1       single clock; also drives the macro's W0_clk/R0_clk
//   reset_n        in   1       asynchronous, active-low reset
//   init_done      out  1       1 once zero-fill complete
//   wr_valid       in   1       write request
//   wr_ready       out  1       write accepted when valid&ready
//   wr_addr        in   ADDR_W  write address
//   wr_data        in   DATA_W  write data
//   wr_mask        in   LANES   lane enables; lane g = bits [g*LANE_W +: LANE_W]
//   rd_req_valid   in   1       read request
//   rd_req_ready   out  1       read accepted when valid&ready
//   rd_req_addr    in   ADDR_W  read address
//   rd_resp_valid  out  1       response FIFO non-empty
//   rd_resp_ready  in   1       consumer pops head
//   rd_resp_data   out  DATA_W  head of response FIFO
//   mem_w_en       out  1       -> W0_en
//   mem_w_addr     out  ADDR_W  -> W0_addr
//   mem_w_data     out  DATA_W  -> W0_data
//   mem_w_mask     out  LANES   -> W0_mask
//   mem_r_en       out  1       -> R0_en
//   mem_r_addr     out  ADDR_W  -> R0_addr
//   mem_r_data     in   DATA_W  <- R0_data (valid only the cycle after mem_r_en)
// BEHAVIOUR
//   FSM states: INIT, RUN. Reset -> INIT, init_ptr=0; all outputs 0 (init_done, wr_ready, rd_req_ready,
//     rd_resp_valid, mem_* = 0). No macro read is issued during INIT.
//   INIT: each cycle mem_w_en=1, addr=init_ptr, data=0, mask=all-ones; init_ptr++. After writing DEPTH-1,
//     -> RUN next cycle. Exactly DEPTH cycles; init_done rises on the first RUN cycle. User requests ignored.
//   RUN writes: wr_ready=1 constant; mem_w_* = wr_* combinationally, mem_w_en = wr_valid. wr_mask=0 with
//     wr_valid=1 is legal and still drives mem_w_en=1 (no lanes change).
//   RUN reads: occ = fifo_count + inflight; rd_req_ready = (occ < RESP_DEPTH), registered-only inputs, no
//     path from rd_resp_ready. Accepted read drives mem_r_en=1, mem_r_addr=rd_req_addr same cycle;
//     inflight<=1. Next cycle mem_r_data is pushed into FIFO unconditionally (space guaranteed by occ).
//   Latency: accept at cycle N -> rd_resp_valid at N+2 earliest (FIFO registered write, then head visible).
//   Ordering: responses strictly in request order.
//   Same-cycle write+read, same address: read returns post-write data for masked lanes, old data for others.
//     Write in cycle N+1 after read issued at N does not affect that read (captured before the edge lands).
//   FIFO full & pop same cycle: pop and push both succeed; count unchanged. Empty: rd_resp_data = don't-care.
//   Reset mid-operation: FIFO flushed, inflight dropped, FSM restarts INIT and re-zeroes whole RAM.
// STRUCTURE
//   Package masked_ram_pkg: ADDR_W/LANES/LANE_W/DATA_W localparams, state enum {ST_INIT, ST_RUN}.
//   Sub-module: resp_fifo (sync FIFO, DEPTH=RESP_DEPTH, WIDTH=DATA_W, push/pop/count/empty).
//   Top holds FSM, init_ptr, inflight flag, occupancy ready logic, mem port muxing.
// TESTING
//   Bench instantiates the macro behaviourally with RANDOMIZE_GARBAGE_ASSIGN so uncaptured reads are garbage.
//   1 Reset, idle 70 cycles -> init_done at cycle 64 after reset release; reads of addr 0,31,63 return 0.
//   2 Write addr 5 data all-0x7FFFF mask 16'h00F0, read addr 5 -> lanes 4..7 = 0x7FFFF, others 0.
//   3 Same-cycle write addr 9 lane0=0x12345 mask 16'h0001 + read addr 9 -> response lane0 = 0x12345.
//   4 Back-to-back reads addr 0..15, rd_resp_ready=1 -> 16 responses, 1/cycle, in order, no stall.
//   5 rd_resp_ready=0, spam reads -> exactly 3 accepted, rd_req_ready low; release -> 3 correct pops.
//   6 Assert reset_n=0 with 2 responses queued -> rd_resp_valid=0 immediately; RAM re-zeroed after release.

Source files
------------

// File: rtl/masked_ram_pkg.sv
// Shared geometry and FSM encoding for the masked-write SRAM port controller.
package masked_ram_pkg;
   localparam int ADDR_W     = 6;
   localparam int LANES      = 16;
   localparam int LANE_W     = 19;
   localparam int DATA_W     = LANES * LANE_W;
   localparam int RESP_DEPTH = 3;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;
endpackage

// File: rtl/masked_ram_port_ctrl_resp_fifo.sv
// Small synchronous FIFO holding captured read data until the consumer pops it.
module resp_fifo #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 304,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count,
   output logic             empty
);
   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= bump(wptr_q);
         if (do_pop)  rptr_q <= bump(rptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) store[wptr_q] <= push_data;
   end

   assign pop_data = store[rptr_q];
endmodule

// File: rtl/masked_ram_port_ctrl.sv
// Initiator-side controller for a 1R1W masked-write SRAM: zero-fill after reset,
// lane-masked write forwarding, and 1-cycle reads captured into a response FIFO.
module masked_ram_port_ctrl
   import masked_ram_pkg::*;
#(
   parameter int ADDR_W     = masked_ram_pkg::ADDR_W,
   parameter int LANES      = masked_ram_pkg::LANES,
   parameter int LANE_W     = masked_ram_pkg::LANE_W,
   parameter int RESP_DEPTH = masked_ram_pkg::RESP_DEPTH
) (
   input  logic                      clock,
   input  logic                      reset_n,
   output logic                      init_done,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [LANES*LANE_W-1:0]   wr_data,
   input  logic [LANES-1:0]          wr_mask,
   input  logic                      rd_req_valid,
   output logic                      rd_req_ready,
   input  logic [ADDR_W-1:0]         rd_req_addr,
   output logic                      rd_resp_valid,
   input  logic                      rd_resp_ready,
   output logic [LANES*LANE_W-1:0]   rd_resp_data,
   output logic                      mem_w_en,
   output logic [ADDR_W-1:0]         mem_w_addr,
   output logic [LANES*LANE_W-1:0]   mem_w_data,
   output logic [LANES-1:0]          mem_w_mask,
   output logic                      mem_r_en,
   output logic [ADDR_W-1:0]         mem_r_addr,
   input  logic [LANES*LANE_W-1:0]   mem_r_data
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] init_ptr_q;
   logic              inflight_q;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic [OCC_W-1:0]  occ;

   // Occupancy counts the read already in the macro pipeline, so the FIFO can never overflow
   // and ready depends on registered state only.
   assign occ = {1'b0, fifo_count} + OCC_W'(inflight_q);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= (state_q == ST_INIT) ? init_ptr_q + ADDR_W'(1) : '0;
         inflight_q <= mem_r_en;
      end
   end

   always_comb begin
      state_d      = state_q;
      init_done    = 1'b0;
      wr_ready     = 1'b0;
      rd_req_ready = 1'b0;
      mem_w_en     = 1'b0;
      mem_w_addr   = '0;
      mem_w_data   = '0;
      mem_w_mask   = '0;
      mem_r_en     = 1'b0;
      mem_r_addr   = '0;
      case (state_q)
         ST_INIT: begin
            // Gated by reset_n so the macro sees a quiet port while reset is held.
            mem_w_en   = reset_n;
            mem_w_addr = init_ptr_q;
            mem_w_mask = {LANES{reset_n}};
            if (init_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
         end
         ST_RUN: begin
            init_done    = 1'b1;
            wr_ready     = 1'b1;
            mem_w_en     = wr_valid;
            mem_w_addr   = wr_addr;
            mem_w_data   = wr_data;
            mem_w_mask   = wr_mask;
            rd_req_ready = (occ < OCC_W'(RESP_DEPTH));
            mem_r_en     = rd_req_valid && (occ < OCC_W'(RESP_DEPTH));
            mem_r_addr   = rd_req_addr;
         end
         default: state_d = ST_INIT;
      endcase
   end

   resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (LANES * LANE_W)
   ) u_resp_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (inflight_q),
      .push_data (mem_r_data),
      .pop       (rd_resp_ready),
      .pop_data  (rd_resp_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign rd_resp_valid = !fifo_empty;
endmodule
